// File: rtl/psum_adder_ctrl.sv
// Sequencer for the column psum adder: pops all column FIFOs together, accumulates
// num_pass adder results per word and hands each word downstream via valid/ready.
module psum_adder_ctrl #(
  parameter int col     = 8,
  parameter int out_bw  = 28,
  parameter int acc_bw  = 32,
  parameter int pass_bw = 4,
  parameter int addr_bw = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode_in,
  input  logic [pass_bw-1:0]       num_pass,
  input  logic [addr_bw-1:0]       num_out,
  input  logic [col-1:0]           fifo_valid,
  output logic                     fifo_rd,
  output logic                     reconfigure,
  input  logic signed [out_bw-1:0] adder_s,
  output logic [acc_bw-1:0]        sum_out,
  output logic [addr_bw-1:0]       sum_addr,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    READ = 3'd2,
    ACC  = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t               state_reg, state_next;
  logic [pass_bw-1:0]   pass_cnt_reg, pass_last_reg;
  logic [addr_bw-1:0]   out_cnt_reg, out_last_reg;
  logic [acc_bw-1:0]    acc_reg;
  logic                 reconfigure_reg;
  logic [acc_bw-1:0]    adder_ext;
  logic                 last_pass;
  logic                 last_word;

  assign adder_ext = {{(acc_bw-out_bw){adder_s[out_bw-1]}}, adder_s};
  assign last_pass = (pass_cnt_reg == pass_last_reg);
  assign last_word = (out_cnt_reg == out_last_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)       state_next = WAIT;
      WAIT:    if (&fifo_valid) state_next = READ;
      READ:                     state_next = ACC;
      ACC:                      state_next = last_pass ? OUT : WAIT;
      OUT:     if (sum_ready)   state_next = last_word ? DONE : WAIT;
      DONE:                     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Counters hold "last index" values so a zero count behaves like one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt_reg    <= '0;
      pass_last_reg   <= '0;
      out_cnt_reg     <= '0;
      out_last_reg    <= '0;
      acc_reg         <= '0;
      reconfigure_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pass_last_reg   <= (num_pass == '0) ? '0 : num_pass - pass_bw'(1);
            out_last_reg    <= (num_out == '0) ? '0 : num_out - addr_bw'(1);
            reconfigure_reg <= mode_in;
            pass_cnt_reg    <= '0;
            out_cnt_reg     <= '0;
            acc_reg         <= '0;
          end
        end
        ACC: begin
          acc_reg <= (pass_cnt_reg == '0) ? adder_ext : acc_reg + adder_ext;
          if (!last_pass) pass_cnt_reg <= pass_cnt_reg + pass_bw'(1);
        end
        OUT: begin
          if (sum_ready && !last_word) begin
            out_cnt_reg  <= out_cnt_reg + addr_bw'(1);
            pass_cnt_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd     = (state_reg == READ);
  assign sum_valid   = (state_reg == OUT);
  assign done        = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign sum_out     = acc_reg;
  assign sum_addr    = out_cnt_reg;
  assign reconfigure = reconfigure_reg;

endmodule

// File: tb/tb_psum_adder_ctrl.sv
// Randomized bench: models the column FIFOs as a stream of popped adder sums and
// predicts every output word as the plain wrapped sum of its group of pops.
module tb_psum_adder_ctrl;
  localparam int COL = 8, OUT_BW = 28, ACC_BW = 32, PASS_BW = 4, ADDR_BW = 4;

  logic                     clk, reset, start, mode_in;
  logic [PASS_BW-1:0]       num_pass;
  logic [ADDR_BW-1:0]       num_out;
  logic [COL-1:0]           fifo_valid;
  logic                     fifo_rd, reconfigure;
  logic signed [OUT_BW-1:0] adder_s;
  logic [ACC_BW-1:0]        sum_out;
  logic [ADDR_BW-1:0]       sum_addr;
  logic                     sum_valid, sum_ready, busy, done;

  psum_adder_ctrl #(.col(COL), .out_bw(OUT_BW), .acc_bw(ACC_BW),
                    .pass_bw(PASS_BW), .addr_bw(ADDR_BW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
    .num_pass(num_pass), .num_out(num_out), .fifo_valid(fifo_valid),
    .fifo_rd(fifo_rd), .reconfigure(reconfigure), .adder_s(adder_s),
    .sum_out(sum_out), .sum_addr(sum_addr), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [OUT_BW-1:0] pop_q[$];
  logic rd_prev;
  logic [COL-1:0] fv_last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word w is the wrapped sum of pops w*p .. w*p+p-1, each sign-extended.
  function automatic logic [31:0] exp_word(input int w, input int p);
    logic [31:0] s;
    logic [31:0] v;
    s = '0;
    for (int i = 0; i < p; i++) begin
      v = int'(pop_q[w*p+i]);
      s = s + v;
    end
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_fifo_rd"}, 64'(fifo_rd), 0);
    check_val({tag, "_sum_valid"}, 64'(sum_valid), 0);
    check_val({tag, "_busy"}, 64'(busy), 0);
    check_val({tag, "_done"}, 64'(done), 0);
    check_val({tag, "_reconfigure"}, 64'(reconfigure), 0);
    check_val({tag, "_sum_out"}, 64'(sum_out), 0);
    check_val({tag, "_sum_addr"}, 64'(sum_addr), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    start = 1'b0;
    fifo_valid = '1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_release_fifo_rd", 64'(fifo_rd), 0);
    check_val("rst_release_busy", 64'(busy), 0);
    rd_prev = 1'b0;
  endtask

  task automatic run_job(input logic mode, input int np, input int nout,
                         input int ready_pct, input int full_pct, input int abort_at);
    int p, n, word, pops, cyc;
    bit fin;
    p = (np == 0) ? 1 : np;
    n = (nout == 0) ? 1 : nout;
    word = 0; pops = 0; cyc = 0; fin = 0;
    pop_q.delete();
    @(negedge clk);
    start = 1'b1; mode_in = mode;
    num_pass = PASS_BW'(np); num_out = ADDR_BW'(nout);
    fifo_valid = COL'($urandom); sum_ready = 1'(($urandom));
    fv_last = fifo_valid;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_at) begin
        do_reset();
        $display("job np=%0d nout=%0d mode=%0d aborted by reset at cycle %0d", np, nout, mode, cyc);
        return;
      end
      check_val("reconfigure", 64'(reconfigure), 64'(mode));
      check_val("busy", 64'(busy), 1);
      if (fifo_rd) begin
        check_val("rd_all_valid", 64'(&fv_last), 1);
        check_val("rd_single", 64'(rd_prev), 0);
        check_val("rd_not_in_out", 64'(sum_valid), 0);
        pops++;
        adder_s = OUT_BW'($urandom);
        pop_q.push_back(adder_s);
      end else if (!rd_prev) begin
        adder_s = OUT_BW'($urandom);
      end
      rd_prev = fifo_rd;
      if (sum_valid) begin
        check_val("word_pops", 64'(pops), 64'((word+1)*p));
        if (pops == (word+1)*p)
          check_val("sum_out", 64'(sum_out), 64'(exp_word(word, p)));
        check_val("sum_addr", 64'(sum_addr), 64'(word));
        sum_ready = ($urandom_range(0, 99) < ready_pct);
        if (sum_ready) word++;
      end else begin
        sum_ready = 1'($urandom);
      end
      if (done) begin
        check_val("done_words", 64'(word), 64'(n));
        check_val("done_pops", 64'(pops), 64'(n*p));
        fin = 1;
        start = 1'b0;
      end else begin
        start = ($urandom_range(0, 9) == 0);
        mode_in = 1'($urandom);
        num_pass = PASS_BW'($urandom);
        num_out = ADDR_BW'($urandom);
      end
      fifo_valid = '1;
      if ($urandom_range(0, 99) >= full_pct) fifo_valid[$urandom_range(0, COL-1)] = 1'b0;
      fv_last = fifo_valid;
    end
    check_val("job_finished", 64'(fin), 1);
    start = 1'b0;
    fifo_valid = '1;
    @(negedge clk);
    check_val("idle_busy", 64'(busy), 0);
    check_val("idle_done", 64'(done), 0);
    @(negedge clk);
    check_val("idle_no_pop", 64'(fifo_rd), 0);
    rd_prev = 1'b0;
    $display("job np=%0d nout=%0d mode=%0d words=%0d pops=%0d cycles=%0d", np, nout, mode, word, pops, cyc);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode_in = 1'b0; num_pass = '0; num_out = '0;
    fifo_valid = '0; adder_s = '0; sum_ready = 1'b0; rd_prev = 1'b0; fv_last = '0;
    @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    fifo_valid = '1;
    @(negedge clk);
    check_val("por_release_fifo_rd", 64'(fifo_rd), 0);
    check_val("por_release_busy", 64'(busy), 0);

    run_job(1'b0, 3, 1, 100, 100, 0);
    run_job(1'b0, 3, 1, 100, 30, 0);
    run_job(1'b1, 1, 2, 20, 100, 0);
    run_job(1'b0, 0, 0, 50, 80, 0);
    run_job(1'b1, 4, 3, 50, 60, 25);
    run_job(1'b1, 2, 2, 60, 90, 0);
    run_job(1'b0, 15, 15, 70, 90, 0);
    for (int j = 0; j < 20; j++)
      run_job(1'($urandom), $urandom_range(0, 5), $urandom_range(0, 4),
              $urandom_range(20, 100), $urandom_range(30, 100), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
